// File: rtl/home_zone_controller.sv
// home_zone_controller: scans NZONES rooms of sensor data, one zone per cycle,
// and drives per-zone fan and light relays. Each zone has run-time thresholds,
// temperature hysteresis and a light-hold timer counted in scans.
//
// Scan sequence: IDLE -> LATCH -> EVAL x NZONES -> COMMIT -> READY -> LATCH ...
// LATCH snapshots the sensor inputs and the threshold registers. EVAL works only
// from those snapshots, so input changes or configuration writes after LATCH
// reach the relays no earlier than the following scan. COMMIT moves all zone
// decisions to the relay outputs at once. scan_done is high during READY only.
module home_zone_controller #(
    parameter int              NZONES       = 4,
    parameter int              DW           = 8,
    parameter int              LW           = 10,
    parameter int              HOLD_W       = 8,
    parameter logic [HOLD_W-1:0] HOLD_SCANS = 8'd20,
    parameter logic [DW-1:0]   TEMP_HI_DEF  = 8'd28,
    parameter logic [DW-1:0]   TEMP_LO_DEF  = 8'd24,
    parameter logic [LW-1:0]   LIGHT_TH_DEF = 10'd500
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NZONES*DW-1:0] temp_in,
    input  logic [NZONES*LW-1:0] light_in,
    input  logic [NZONES-1:0]    motion_in,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_zone,
    input  logic [DW-1:0]        cfg_temp_hi,
    input  logic [DW-1:0]        cfg_temp_lo,
    input  logic [LW-1:0]        cfg_light_th,
    output logic [NZONES-1:0]    fan_ctrl,
    output logic [NZONES-1:0]    light_ctrl,
    output logic                 scan_done,
    output logic                 sys_ready
);

    localparam int IW = (NZONES > 1) ? $clog2(NZONES) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_EVAL   = 3'd2;
    localparam logic [2:0] S_COMMIT = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;

    logic [2:0]           state;
    logic [IW-1:0]        idx;

    // Live threshold registers (written by configuration)
    logic [DW-1:0]        hi_r [NZONES];
    logic [DW-1:0]        lo_r [NZONES];
    logic [LW-1:0]        th_r [NZONES];

    // Per-scan snapshots taken in LATCH
    logic [DW-1:0]        hi_l [NZONES];
    logic [DW-1:0]        lo_l [NZONES];
    logic [LW-1:0]        th_l [NZONES];
    logic [NZONES*DW-1:0] temp_l;
    logic [NZONES*LW-1:0] light_l;
    logic [NZONES-1:0]    motion_l;

    // Zone decisions accumulated during EVAL; fan_nxt also serves as hysteresis memory
    logic [NZONES-1:0]    fan_nxt;
    logic [NZONES-1:0]    light_nxt;
    logic [HOLD_W-1:0]    hold_cnt [NZONES];

    logic [DW-1:0]        cur_t;
    logic [LW-1:0]        cur_l;
    logic                 cur_m;
    logic                 fan_d;
    logic                 light_d;
    logic [HOLD_W-1:0]    hold_d;
    logic                 cfg_hit;

    assign cfg_hit = cfg_we && ({1'b0, cfg_zone} < 5'(NZONES));

    // Configuration writes land in the live registers one edge after cfg_we
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int z = 0; z < NZONES; z++) begin
                hi_r[z] <= TEMP_HI_DEF;
                lo_r[z] <= TEMP_LO_DEF;
                th_r[z] <= LIGHT_TH_DEF;
            end
        end else if (cfg_hit) begin
            hi_r[cfg_zone[IW-1:0]] <= cfg_temp_hi;
            lo_r[cfg_zone[IW-1:0]] <= cfg_temp_lo;
            th_r[cfg_zone[IW-1:0]] <= cfg_light_th;
        end
    end

    // Evaluate the zone selected by idx from the latched snapshot
    always_comb begin
        cur_t   = temp_l[idx*DW +: DW];
        cur_l   = light_l[idx*LW +: LW];
        cur_m   = motion_l[idx];
        fan_d   = fan_nxt[idx];
        if (hi_l[idx] <= lo_l[idx]) begin
            fan_d = 1'b0;
        end else if (cur_t > hi_l[idx]) begin
            fan_d = 1'b1;
        end else if (cur_t < lo_l[idx]) begin
            fan_d = 1'b0;
        end
        light_d = 1'b0;
        hold_d  = hold_cnt[idx];
        if (cur_m && (cur_l < th_l[idx])) begin
            light_d = 1'b1;
            hold_d  = HOLD_SCANS;
        end else if (hold_cnt[idx] != '0) begin
            light_d = 1'b1;
            hold_d  = hold_cnt[idx] - HOLD_W'(1);
        end
    end

    // Scan FSM with snapshot, per-zone update and output commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            temp_l     <= '0;
            light_l    <= '0;
            motion_l   <= '0;
            fan_nxt    <= '0;
            light_nxt  <= '0;
            fan_ctrl   <= '0;
            light_ctrl <= '0;
            scan_done  <= 1'b0;
            sys_ready  <= 1'b0;
            for (int z = 0; z < NZONES; z++) begin
                hold_cnt[z] <= '0;
                hi_l[z]     <= TEMP_HI_DEF;
                lo_l[z]     <= TEMP_LO_DEF;
                th_l[z]     <= LIGHT_TH_DEF;
            end
        end else begin
            scan_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    temp_l   <= temp_in;
                    light_l  <= light_in;
                    motion_l <= motion_in;
                    for (int z = 0; z < NZONES; z++) begin
                        hi_l[z] <= hi_r[z];
                        lo_l[z] <= lo_r[z];
                        th_l[z] <= th_r[z];
                    end
                    idx   <= '0;
                    state <= S_EVAL;
                end
                S_EVAL: begin
                    fan_nxt[idx]   <= fan_d;
                    light_nxt[idx] <= light_d;
                    hold_cnt[idx]  <= hold_d;
                    if (idx == IW'(NZONES - 1)) begin
                        state <= S_COMMIT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_COMMIT: begin
                    fan_ctrl   <= fan_nxt;
                    light_ctrl <= light_nxt;
                    scan_done  <= 1'b1;
                    sys_ready  <= 1'b1;
                    state      <= S_READY;
                end
                S_READY: begin
                    state <= S_LATCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_home_zone_controller.sv
// Bench for home_zone_controller. A driver sets each scan's inputs while the
// DUT is in READY (so they are stable through LATCH), scrambles them during
// EVAL, and issues configuration writes at chosen points of the scan. A
// zone-level reference model computes each scan's relay outputs and pushes them
// into exp_q; a monitor pops and compares on every scan_done pulse.
module tb_home_zone_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] temp_in;
    logic [39:0] light_in;
    logic [3:0]  motion_in;
    logic        cfg_we;
    logic [3:0]  cfg_zone;
    logic [7:0]  cfg_temp_hi;
    logic [7:0]  cfg_temp_lo;
    logic [9:0]  cfg_light_th;
    logic [3:0]  fan_ctrl;
    logic [3:0]  light_ctrl;
    logic        scan_done;
    logic        sys_ready;

    home_zone_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .temp_in      (temp_in),
        .light_in     (light_in),
        .motion_in    (motion_in),
        .cfg_we       (cfg_we),
        .cfg_zone     (cfg_zone),
        .cfg_temp_hi  (cfg_temp_hi),
        .cfg_temp_lo  (cfg_temp_lo),
        .cfg_light_th (cfg_light_th),
        .fan_ctrl     (fan_ctrl),
        .light_ctrl   (light_ctrl),
        .scan_done    (scan_done),
        .sys_ready    (sys_ready)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard entry: {fan[3:0], light[3:0], sys_ready}
    logic [8:0] exp_q[$];

    // reference model state
    int cur_t[4];
    int cur_l[4];
    bit cur_m[4];
    int m_hi[4];
    int m_lo[4];
    int m_th[4];
    bit m_fan[4];
    bit m_light[4];
    int m_cnt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 4; z++) begin
            m_hi[z] = 28; m_lo[z] = 24; m_th[z] = 500;
            m_fan[z] = 0; m_light[z] = 0; m_cnt[z] = 0;
        end
    endtask

    task automatic model_write(input int zone, input int hi, input int lo, input int th);
        if (zone < 4) begin
            m_hi[zone] = hi; m_lo[zone] = lo; m_th[zone] = th;
        end
    endtask

    // One scan of every zone under the current thresholds, then queue the result
    task automatic model_scan();
        logic [8:0] e;
        for (int z = 0; z < 4; z++) begin
            if (m_hi[z] <= m_lo[z])      m_fan[z] = 0;
            else if (cur_t[z] > m_hi[z]) m_fan[z] = 1;
            else if (cur_t[z] < m_lo[z]) m_fan[z] = 0;
            if (cur_m[z] && cur_l[z] < m_th[z]) begin
                m_light[z] = 1; m_cnt[z] = 20;
            end else if (m_cnt[z] > 0) begin
                m_light[z] = 1; m_cnt[z] = m_cnt[z] - 1;
            end else begin
                m_light[z] = 0;
            end
        end
        e = {m_fan[3], m_fan[2], m_fan[1], m_fan[0],
             m_light[3], m_light[2], m_light[1], m_light[0], 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic drive_inputs();
        for (int z = 0; z < 4; z++) begin
            temp_in[z*8 +: 8]   = 8'(cur_t[z]);
            light_in[z*10 +: 10] = 10'(cur_l[z]);
            motion_in[z]        = cur_m[z];
        end
    endtask

    task automatic set_zone(input int z, input int t, input int l, input bit m);
        cur_t[z] = t; cur_l[z] = l; cur_m[z] = m;
    endtask

    task automatic cfg_drive(input int zone, input int hi, input int lo, input int th);
        cfg_we       = 1'b1;
        cfg_zone     = 4'(zone);
        cfg_temp_hi  = 8'(hi);
        cfg_temp_lo  = 8'(lo);
        cfg_light_th = 10'(th);
    endtask

    task automatic print_summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    endtask

    // Bounded wait for the next scan_done; returns the negedges waited
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (scan_done !== 1'b1 && cyc < 40);
        if (scan_done !== 1'b1) begin
            n_err++;
            $display("FAIL scan_timeout: no scan_done within %0d cycles", cyc);
            print_summary();
            $fatal(1, "scan_done never arrived");
        end
    endtask

    // Called in the READY cycle. cfg_mode: 0 none, 1 write in READY (affects this
    // scan), 2 write in LATCH, 3 write in EVAL (both affect the next scan).
    task automatic do_scan(input int cfg_mode, input int cz, input int chi,
                           input int clo, input int cth);
        int cyc;
        drive_inputs();
        cfg_we = 1'b0;
        if (cfg_mode == 1) begin
            cfg_drive(cz, chi, clo, cth);
            model_write(cz, chi, clo, cth);
        end
        model_scan();
        @(negedge clk);  // LATCH
        cfg_we = 1'b0;
        if (cfg_mode == 2) begin
            cfg_drive(cz, chi, clo, cth);
            model_write(cz, chi, clo, cth);
        end
        @(negedge clk);  // EVAL zone 0
        cfg_we    = 1'b0;
        temp_in   = $urandom;
        light_in  = {$urandom, $urandom};
        motion_in = 4'($urandom);
        if (cfg_mode == 3) begin
            cfg_drive(cz, chi, clo, cth);
            model_write(cz, chi, clo, cth);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        wait_done(cyc);
    endtask

    // monitor: compare every presented scan result against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && scan_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scan_unexpected: scan_done with empty queue at %0t", $time);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("scan_fan",       32'(fan_ctrl),   32'(e[8:5]));
                chk("scan_light",     32'(light_ctrl), 32'(e[4:1]));
                chk("scan_sys_ready", 32'(sys_ready),  32'(e[0]));
            end
        end
    end

    initial begin
        int cyc;
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_zone = '0; cfg_temp_hi = '0; cfg_temp_lo = '0; cfg_light_th = '0;
        for (int z = 0; z < 4; z++) set_zone(z, 0, 0, 0);
        drive_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_fan",       32'(fan_ctrl),   32'h0);
        chk("rst_light",     32'(light_ctrl), 32'h0);
        chk("rst_scan_done", 32'(scan_done),  32'h0);
        chk("rst_sys_ready", 32'(sys_ready),  32'h0);

        // first scan with all inputs zero: scan_done at cycle 7
        model_scan();
        rst_n = 1'b1;
        @(negedge clk);
        chk("pre_scan_sys_ready", 32'(sys_ready), 32'h0);
        wait_done(cyc);
        chk("first_scan_latency", 32'(cyc + 1), 32'd7);

        // zone 2 hysteresis 29 -> 26 -> 23, other zones parked in the dead band
        for (int z = 0; z < 4; z++) set_zone(z, 25, 800, 0);
        set_zone(2, 29, 800, 0); do_scan(0, 0, 0, 0, 0);
        set_zone(2, 26, 800, 0); do_scan(0, 0, 0, 0, 0);
        set_zone(2, 23, 800, 0); do_scan(0, 0, 0, 0, 0);

        // zone 1 motion in the dark for one scan, then hold timer runs out
        set_zone(1, 25, 300, 1); do_scan(0, 0, 0, 0, 0);
        set_zone(1, 25, 300, 0);
        for (int i = 0; i < 22; i++) do_scan(0, 0, 0, 0, 0);

        // zone 0 motion too bright, then raise the darkness threshold mid-scan
        set_zone(0, 25, 600, 1);
        do_scan(3, 0, 28, 24, 700);
        do_scan(0, 0, 0, 0, 0);
        set_zone(0, 25, 600, 0);

        // out-of-range zone write ignored; hi == lo forces the fan off
        do_scan(1, 5, 10, 5, 1000);
        set_zone(3, 50, 800, 0);
        do_scan(0, 0, 0, 0, 0);
        do_scan(1, 3, 20, 20, 500);
        do_scan(0, 0, 0, 0, 0);
        // write landing in LATCH only applies to the scan after
        do_scan(2, 3, 30, 25, 500);
        do_scan(0, 0, 0, 0, 0);

        // randomized scans with writes at random points
        for (int i = 0; i < 40; i++) begin
            for (int z = 0; z < 4; z++)
                set_zone(z, $urandom_range(15, 35), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
            do_scan($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(20, 32),
                    $urandom_range(18, 30), $urandom_range(200, 900));
        end

        // reset mid-EVAL with fans and lights on
        for (int z = 0; z < 4; z++) set_zone(z, 60, 10, 1);
        do_scan(1, 0, 28, 24, 500);
        do_scan(0, 0, 0, 0, 0);
        drive_inputs();
        @(negedge clk);  // LATCH
        @(negedge clk);  // EVAL 0
        @(negedge clk);  // EVAL 1
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_fan",       32'(fan_ctrl),   32'h0);
        chk("midrst_light",     32'(light_ctrl), 32'h0);
        chk("midrst_scan_done", 32'(scan_done),  32'h0);
        chk("midrst_sys_ready", 32'(sys_ready),  32'h0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        // restart: default thresholds and cleared hold counters
        for (int z = 0; z < 4; z++) set_zone(z, 27, 900, 0);
        set_zone(1, 29, 900, 0);
        drive_inputs();
        model_scan();
        rst_n = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        chk("restart_latency", 32'(cyc + 1), 32'd7);
        set_zone(2, 23, 400, 1);
        do_scan(0, 0, 0, 0, 0);
        do_scan(0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        print_summary();
        $finish;
    end

endmodule
